// File: rtl/dla_multi_walker.sv
// Round-robin random-walk engine for DLA: several particles share one checker and one VRAM port.
// Optional build macro DLA_WALK_STATS_EN adds saturating retirement counters by cause.
module dla_multi_walker #(
    parameter int unsigned AVN_AW      = 19,
    parameter int unsigned AVN_DW      = 16,
    parameter int unsigned H_SIZE      = 10,
    parameter int unsigned V_SIZE      = 10,
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned NUM_WALKERS = 4,
    parameter int unsigned MAX_STEPS   = 4096,
    parameter int unsigned DIR8        = 1,
    localparam int unsigned IdW        = (NUM_WALKERS > 1) ? $clog2(NUM_WALKERS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [H_SIZE-1:0] walk_init_x_i,
    input  logic [V_SIZE-1:0] walk_init_y_i,
    input  logic              walk_start_i,
    output logic              walk_ready_o,
    output logic              walk_done_o,
    output logic              walk_valid_o,
    output logic              walk_timeout_o,
    output logic [IdW-1:0]    walk_id_o,
    output logic [AVN_AW-1:0] vram_avn_address_o,
    output logic              vram_avn_write_o,
    output logic [AVN_DW-1:0] vram_avn_writedata_o,
    input  logic              vram_avn_waitrequest_i,
    output logic [H_SIZE-1:0] check_x_o,
    output logic [V_SIZE-1:0] check_y_o,
    output logic              check_start_o,
    input  logic              check_done_i,
    input  logic              hit_boundary_i,
`ifdef DLA_WALK_STATS_EN
    output logic [15:0]       stat_stuck_o,
    output logic [15:0]       stat_boundary_o,
    output logic [15:0]       stat_timeout_o,
`endif
    input  logic              hit_neighbor_i
);
    localparam int unsigned StepW   = $clog2(MAX_STEPS + 1);
    localparam logic [15:0] LfsrTap = 16'hD008;

    typedef enum logic [4:0] {
        SIdle  = 5'b00001,
        SCheck = 5'b00010,
        SWait  = 5'b00100,
        SMove  = 5'b01000,
        SWrite = 5'b10000
    } state_e;

    state_e                  state_q, state_d;
    logic [IdW-1:0]          ptr_q, ptr_d, cur_q, cur_d, cur_next;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [AVN_AW-1:0]       addr_q, addr_d;
    logic [NUM_WALKERS-1:0]  valid_q, valid_d;
    logic [H_SIZE-1:0]       x_q [NUM_WALKERS];
    logic [H_SIZE-1:0]       x_d [NUM_WALKERS];
    logic [V_SIZE-1:0]       y_q [NUM_WALKERS];
    logic [V_SIZE-1:0]       y_d [NUM_WALKERS];
    logic [StepW-1:0]        steps_q [NUM_WALKERS];
    logic [StepW-1:0]        steps_d [NUM_WALKERS];

    logic           sel_found;
    logic [IdW-1:0] sel_idx, scan_idx, free_idx;
    logic           x_inc, x_dec, y_inc, y_dec, retire;

    assign walk_ready_o         = ~&valid_q;
    assign walk_id_o            = cur_q;
    assign vram_avn_address_o   = addr_q;
    assign vram_avn_writedata_o = '1;
    assign check_x_o            = x_q[cur_q];
    assign check_y_o            = y_q[cur_q];
    assign cur_next = (cur_q == IdW'(NUM_WALKERS - 1)) ? '0 : cur_q + IdW'(1);

    // First valid slot at or after the pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_WALKERS; i++) begin
            scan_idx = IdW'((32'(ptr_q) + 32'(i)) % 32'(NUM_WALKERS));
            if (!sel_found && valid_q[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = NUM_WALKERS - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IdW'(i);
        end
    end

    always_comb begin
        x_inc = 1'b0;
        x_dec = 1'b0;
        y_inc = 1'b0;
        y_dec = 1'b0;
        if (DIR8 != 0) begin
            case (lfsr_q[2:0])
                3'd0:    begin x_dec = 1'b1; y_dec = 1'b1; end
                3'd1:    y_dec = 1'b1;
                3'd2:    begin x_inc = 1'b1; y_dec = 1'b1; end
                3'd3:    x_dec = 1'b1;
                3'd4:    x_inc = 1'b1;
                3'd5:    begin x_dec = 1'b1; y_inc = 1'b1; end
                3'd6:    y_inc = 1'b1;
                default: begin x_inc = 1'b1; y_inc = 1'b1; end
            endcase
        end else begin
            case (lfsr_q[1:0])
                2'd0:    y_dec = 1'b1;
                2'd1:    x_dec = 1'b1;
                2'd2:    x_inc = 1'b1;
                default: y_inc = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cur_d          = cur_q;
        lfsr_d         = lfsr_q;
        addr_d         = addr_q;
        valid_d        = valid_q;
        x_d            = x_q;
        y_d            = y_q;
        steps_d        = steps_q;
        check_start_o  = 1'b0;
        vram_avn_write_o = 1'b0;
        walk_done_o    = 1'b0;
        walk_valid_o   = 1'b0;
        walk_timeout_o = 1'b0;
        retire         = 1'b0;
        unique case (state_q)
            SIdle: begin
                if (sel_found) begin
                    cur_d   = sel_idx;
                    state_d = SCheck;
                end
            end
            SCheck: begin
                check_start_o = 1'b1;
                addr_d  = AVN_AW'(32'(x_q[cur_q]) + 32'(y_q[cur_q]) * 32'(H_DISPLAY));
                state_d = SWait;
            end
            SWait: begin
                if (check_done_i) begin
                    if (hit_boundary_i) begin
                        retire = 1'b1;
                    end else if (hit_neighbor_i) begin
                        state_d = SWrite;
                    end else if (steps_q[cur_q] == StepW'(MAX_STEPS)) begin
                        retire         = 1'b1;
                        walk_timeout_o = 1'b1;
                    end else begin
                        state_d = SMove;
                    end
                end
            end
            SMove: begin
                if (x_inc) x_d[cur_q] = x_q[cur_q] + H_SIZE'(1);
                if (x_dec) x_d[cur_q] = x_q[cur_q] - H_SIZE'(1);
                if (y_inc) y_d[cur_q] = y_q[cur_q] + V_SIZE'(1);
                if (y_dec) y_d[cur_q] = y_q[cur_q] - V_SIZE'(1);
                steps_d[cur_q] = steps_q[cur_q] + StepW'(1);
                lfsr_d  = {lfsr_q[14:0], ^(lfsr_q & LfsrTap)};
                ptr_d   = cur_next;
                state_d = SIdle;
            end
            SWrite: begin
                vram_avn_write_o = 1'b1;
                if (!vram_avn_waitrequest_i) begin
                    retire       = 1'b1;
                    walk_valid_o = 1'b1;
                end
            end
            default: state_d = SIdle;
        endcase
        if (retire) begin
            walk_done_o    = 1'b1;
            valid_d[cur_q] = 1'b0;
            ptr_d          = cur_next;
            state_d        = SIdle;
        end
        // A free slot is never the one being retired, so both updates can land together.
        if (walk_start_i && walk_ready_o) begin
            valid_d[free_idx] = 1'b1;
            x_d[free_idx]     = walk_init_x_i;
            y_d[free_idx]     = walk_init_y_i;
            steps_d[free_idx] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SIdle;
            ptr_q   <= '0;
            cur_q   <= '0;
            lfsr_q  <= 16'hFFFF;
            addr_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < NUM_WALKERS; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                steps_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            lfsr_q  <= lfsr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            steps_q <= steps_d;
        end
    end

`ifdef DLA_WALK_STATS_EN
    logic [15:0] stat_stuck_q, stat_boundary_q, stat_timeout_q;
    logic        boundary_retire;

    assign boundary_retire = walk_done_o && !walk_valid_o && !walk_timeout_o;
    assign stat_stuck_o    = stat_stuck_q;
    assign stat_boundary_o = stat_boundary_q;
    assign stat_timeout_o  = stat_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stuck_q    <= '0;
            stat_boundary_q <= '0;
            stat_timeout_q  <= '0;
        end else begin
            if (walk_valid_o && stat_stuck_q != 16'hFFFF) stat_stuck_q <= stat_stuck_q + 16'd1;
            if (boundary_retire && stat_boundary_q != 16'hFFFF) begin
                stat_boundary_q <= stat_boundary_q + 16'd1;
            end
            if (walk_timeout_o && stat_timeout_q != 16'hFFFF) begin
                stat_timeout_q <= stat_timeout_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dla_multi_walker.sv
// Directed bench for dla_multi_walker: an 8-direction and a 4-direction instance run in lockstep.
module tb_dla_multi_walker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] init_x = '0, init_y = '0;
    logic       start = 1'b0, waitreq = 1'b0;
    logic       check_done = 1'b0, resp_b = 1'b0, resp_n = 1'b0;

    logic        a_ready, a_done, a_valid, a_timeout, a_write, a_cstart;
    logic [1:0]  a_id;
    logic [18:0] a_addr;
    logic [15:0] a_wdata;
    logic [9:0]  a_cx, a_cy;
    logic        b_ready, b_done, b_valid, b_timeout, b_write, b_cstart;
    logic [1:0]  b_id;
    logic [18:0] b_addr;
    logic [15:0] b_wdata;
    logic [9:0]  b_cx, b_cy;

    int n_assert = 0, n_fail = 0;
    int ck_n, wr_n, done_n, moves_n;
    int cxa[8], cya[8], cxb[8], cyb[8];
    int pxa, pya, pxb, pyb, dxa, dya, dxb, dyb;
    bit delta_en = 1'b0, have_prev = 1'b0, pending = 1'b0, ok8, ok4;

    always #5 clk = ~clk;

    dla_multi_walker #(.NUM_WALKERS(4), .MAX_STEPS(8), .DIR8(1)) u_a (
        .clk(clk), .rst(rst), .walk_init_x_i(init_x), .walk_init_y_i(init_y),
        .walk_start_i(start), .walk_ready_o(a_ready), .walk_done_o(a_done),
        .walk_valid_o(a_valid), .walk_timeout_o(a_timeout), .walk_id_o(a_id),
        .vram_avn_address_o(a_addr), .vram_avn_write_o(a_write),
        .vram_avn_writedata_o(a_wdata), .vram_avn_waitrequest_i(waitreq),
        .check_x_o(a_cx), .check_y_o(a_cy), .check_start_o(a_cstart),
        .check_done_i(check_done), .hit_boundary_i(resp_b), .hit_neighbor_i(resp_n)
    );

    dla_multi_walker #(.NUM_WALKERS(4), .MAX_STEPS(8), .DIR8(0)) u_b (
        .clk(clk), .rst(rst), .walk_init_x_i(init_x), .walk_init_y_i(init_y),
        .walk_start_i(start), .walk_ready_o(b_ready), .walk_done_o(b_done),
        .walk_valid_o(b_valid), .walk_timeout_o(b_timeout), .walk_id_o(b_id),
        .vram_avn_address_o(b_addr), .vram_avn_write_o(b_write),
        .vram_avn_writedata_o(b_wdata), .vram_avn_waitrequest_i(waitreq),
        .check_x_o(b_cx), .check_y_o(b_cy), .check_start_o(b_cstart),
        .check_done_i(check_done), .hit_boundary_i(resp_b), .hit_neighbor_i(resp_n)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checker model: result valid one cycle after the request.
    always @(posedge clk) begin
        #1;
        check_done = pending;
        pending    = a_cstart && !rst;
    end

    always @(negedge clk) begin
        if (a_cstart) begin
            if (ck_n < 8) begin
                cxa[ck_n] = int'(a_cx); cya[ck_n] = int'(a_cy);
                cxb[ck_n] = int'(b_cx); cyb[ck_n] = int'(b_cy);
            end
            ck_n++;
            if (delta_en && have_prev) begin
                dxa = int'(a_cx) - pxa; dya = int'(a_cy) - pya;
                dxb = int'(b_cx) - pxb; dyb = int'(b_cy) - pyb;
                ok8 = (dxa >= -1 && dxa <= 1 && dya >= -1 && dya <= 1 && (dxa != 0 || dya != 0));
                ok4 = ((dxb == 0 && (dyb == 1 || dyb == -1)) ||
                       (dyb == 0 && (dxb == 1 || dxb == -1)));
                chk("dir8_move", int'(ok8), 1);
                chk("dir4_move", int'(ok4), 1);
                moves_n++;
            end
            pxa = int'(a_cx); pya = int'(a_cy); pxb = int'(b_cx); pyb = int'(b_cy);
            have_prev = 1'b1;
        end
        if (a_write) wr_n++;
        if (a_done) begin
            done_n++;
            have_prev = 1'b0;
        end
    end

    task automatic clear();
        ck_n = 0; wr_n = 0; done_n = 0; moves_n = 0; have_prev = 1'b0;
    endtask

    task automatic load(input int x, input int y);
        @(posedge clk); #1;
        init_x = 10'(x); init_y = 10'(y); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (a_done) break;
        end
        chk(tag, int'(a_done), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(a_ready), 1);
        chk("rst_done", int'(a_done), 0);
        chk("rst_write", int'(a_write), 0);
        chk("rst_cstart", int'(a_cstart), 0);
        chk("rst_addr", int'(a_addr), 0);
        chk("rst_timeout", int'(a_timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Neighbor hit on first check: single write at 100 + 50*640.
        resp_n = 1'b1; clear();
        load(100, 50);
        wait_done("t1_done_seen", 30);
        chk("t1_valid", int'(a_valid), 1);
        chk("t1_timeout", int'(a_timeout), 0);
        chk("t1_id", int'(a_id), 0);
        chk("t1_write", int'(a_write), 1);
        chk("t1_addr", int'(a_addr), 32100);
        repeat (3) @(negedge clk);
        chk("t1_write_cycles", wr_n, 1);
        chk("t1_done_count", done_n, 1);
        chk("t1_ready", int'(a_ready), 1);

        // Boundary hit: retire without writing.
        resp_n = 1'b0; resp_b = 1'b1; clear();
        load(0, 0);
        wait_done("t2_done_seen", 30);
        chk("t2_valid", int'(a_valid), 0);
        chk("t2_timeout", int'(a_timeout), 0);
        repeat (3) @(negedge clk);
        chk("t2_write_cycles", wr_n, 0);
        chk("t2_checks", ck_n, 1);

        // No hits: 9 checks, 8 moves, then timeout. First moves follow the seed 16'hFFFF.
        resp_b = 1'b0; clear(); delta_en = 1'b1;
        load(300, 200);
        wait_done("t3_done_seen", 100);
        chk("t3_timeout", int'(a_timeout), 1);
        chk("t3_valid", int'(a_valid), 0);
        repeat (3) @(negedge clk);
        chk("t3_checks", ck_n, 9);
        chk("t3_moves", moves_n, 8);
        chk("t3_a_x0", cxa[0], 300); chk("t3_a_y0", cya[0], 200);
        chk("t3_a_x1", cxa[1], 301); chk("t3_a_y1", cya[1], 201);
        chk("t3_a_x2", cxa[2], 301); chk("t3_a_y2", cya[2], 202);
        chk("t3_b_x1", cxb[1], 300); chk("t3_b_y1", cyb[1], 201);
        chk("t3_b_x2", cxb[2], 301); chk("t3_b_y2", cyb[2], 201);

        // Fill all slots, a fifth load must be ignored, service is round-robin.
        delta_en = 1'b0; clear();
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            init_x = 10'(10 * (i + 1)); init_y = 10'd100;
            @(posedge clk); #1;
        end
        init_x = 10'd50;
        @(negedge clk);
        chk("t4_ready_full", int'(a_ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 200 && ck_n < 8; n++) @(negedge clk);
        chk("t4_eight_checks", int'(ck_n >= 8), 1);
        for (int i = 0; i < 4; i++) chk("t4_first_round_x", cxa[i], 10 * (i + 1));
        for (int i = 4; i < 8; i++) begin
            chk("t4_second_round_x", int'(cxa[i] >= 10 * (i - 3) - 1 && cxa[i] <= 10 * (i - 3) + 1), 1);
        end
        chk("t4_no_done", done_n, 0);

        // Mid-operation reset drops every particle.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; clear(); pending = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_rst_checks", ck_n, 0);
        chk("t4_rst_ready", int'(a_ready), 1);
        chk("t4_rst_writes", wr_n, 0);

        // Stalled write: held three cycles, accepted on the fourth.
        resp_n = 1'b1; waitreq = 1'b1; clear();
        load(5, 2);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (a_write) break;
        end
        chk("t5_write_seen", int'(a_write), 1);
        chk("t5_addr", int'(a_addr), 1285);
        chk("t5_done_stall", int'(a_done), 0);
        repeat (2) begin
            @(negedge clk);
            chk("t5_write_hold", int'(a_write), 1);
            chk("t5_addr_hold", int'(a_addr), 1285);
            chk("t5_done_stall", int'(a_done), 0);
        end
        @(posedge clk); #1;
        waitreq = 1'b0;
        @(negedge clk);
        chk("t5_write_accept", int'(a_write), 1);
        chk("t5_done", int'(a_done), 1);
        chk("t5_valid", int'(a_valid), 1);
        chk("t5_addr_accept", int'(a_addr), 1285);
        repeat (3) @(negedge clk);
        chk("t5_write_cycles", wr_n, 4);
        chk("t5_done_count", done_n, 1);

        // 200 moves in total; every move checked for both direction modes.
        resp_n = 1'b0; delta_en = 1'b1; clear();
        for (int k = 0; k < 25; k++) begin
            load(400, 300);
            wait_done("t6_done_seen", 100);
            chk("t6_timeout", int'(a_timeout), 1);
        end
        repeat (2) @(negedge clk);
        chk("t6_moves", moves_n, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dla_multi_walker.md
Name: dla_multi_walker

Overview:
Time-multiplexed random-walk engine for diffusion-limited aggregation. It holds up to NUM_WALKERS particles in flight and services them round-robin through one shared neighbor/boundary checker and one VRAM write port. It adds selectable 4- or 8-direction movement and a per-particle step limit (timeout). It sits between the particle spawner (init coordinates) and the checker/VRAM Avalon arbiter.

Parameters:
AVN_AW, 19, VRAM Avalon address width
AVN_DW, 16, VRAM Avalon data width
H_SIZE, 10, x coordinate width
V_SIZE, 10, y coordinate width
H_DISPLAY, 640, pixels per line, used for address computation
NUM_WALKERS, 4, particle slots (1..16)
MAX_STEPS, 4096, moves allowed per particle before timeout (>=1)
DIR8, 1, 1 = 8-direction moves, 0 = 4-direction moves

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
walk_init_x  in  H_SIZE  spawn x
walk_init_y  in  V_SIZE  spawn y
walk_start  in  1  load request; accepted when walk_ready=1
walk_ready  out  1  at least one free slot
walk_done  out  1  one-cycle pulse: a particle retired
walk_valid  out  1  with walk_done: particle stuck and written
walk_timeout  out  1  with walk_done: retired on step limit
walk_id  out  clog2(NUM_WALKERS) max 1  slot of the retiring particle, qualified by walk_done
vram_avn_address  out  AVN_AW  x + y*H_DISPLAY of the serviced particle
vram_avn_write  out  1  write strobe
vram_avn_writedata  out  AVN_DW  constant all ones
vram_avn_waitrequest  in  1  Avalon stall
check_x  out  H_SIZE  coordinate under check
check_y  out  V_SIZE  coordinate under check
check_start  out  1  one-cycle check request
check_done  in  1  check result valid
hit_boundary  in  1  qualified by check_done
hit_neighbor  in  1  qualified by check_done; boundary has priority

Behaviour:
- Reset: all slots invalid, FSM in S_IDLE, round-robin pointer 0, LFSR = 16'hFFFF. walk_ready=1; all other outputs 0; address 0.
- Slot table: per slot valid, x, y, step counter (clog2(MAX_STEPS+1) bits).
- Load: walk_start & walk_ready loads the lowest-index free slot with init coordinates, steps=0, valid=1. walk_start is ignored when walk_ready=0. Loads are accepted in any FSM state. walk_ready is derived from registered valids, so a slot freed in cycle N is loadable from N+1. A load and a retire on different slots in the same cycle are both honoured.
- One-hot FSM:
  - S_IDLE: if any slot is valid, select the first valid slot at or after the pointer (wrapping) and go to S_CHECK; otherwise stay.
  - S_CHECK: check_start=1 for one cycle; check_x/y = slot coordinates; register vram_avn_address; go to S_WAIT.
  - S_WAIT: hold until check_done.
    - hit_boundary: retire with walk_done=1, valid 0, timeout 0.
    - else hit_neighbor: go to S_WRITE.
    - else if steps==MAX_STEPS: retire with walk_done=1, walk_timeout=1.
    - else go to S_MOVE.
  - S_MOVE: apply the move, steps+1, shift the LFSR once, pointer = slot+1 (mod NUM_WALKERS), go to S_IDLE.
  - S_WRITE: assert vram_avn_write with the address held. In the cycle waitrequest=0: walk_done=walk_valid=1, retire the slot, advance the pointer, go to S_IDLE.
- Every retire frees the slot, advances the pointer past it, and returns to S_IDLE.
- Each serviced particle gets one check and at most one move before the next slot is selected. Per-slot round-trip is check latency + 3 cycles.
- LFSR: dla_lsfr, WIDTH 16, TAP 'hD008, SEED 'hFFFF; shifts only in S_MOVE.
- Directions:
  - DIR8=1, lfsr[2:0]: 0 (-1,-1), 1 (0,-1), 2 (+1,-1), 3 (-1,0), 4 (+1,0), 5 (-1,+1), 6 (0,+1), 7 (+1,+1).
  - DIR8=0, lfsr[1:0]: 0 up, 1 left, 2 right, 3 down.
- Coordinate arithmetic is modulo 2^H_SIZE / 2^V_SIZE; bounds are the checker's responsibility.
- Address arithmetic is truncated to AVN_AW.
- Mid-operation reset discards all particles and any pending write immediately.

Optional Feature:
DLA_WALK_STATS_EN: adds outputs stat_stuck, stat_boundary, stat_timeout, each 16-bit. They count retirements by cause, saturate at 16'hFFFF, and reset to 0. Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Load (100,50) into an empty block; checker returns hit_neighbor on the first check -> exactly one write at address 32100, walk_done=walk_valid=1, walk_id=0, walk_ready=1 afterwards.
- Load (0,0); checker returns hit_boundary -> walk_done=1, walk_valid=0, no vram_avn_write ever asserted.
- MAX_STEPS=8; checker never hits -> exactly 9 check_start pulses and 8 moves, then walk_done=walk_timeout=1.
- Load 4 particles at distinct x (10,20,30,40); checker never hits -> walk_ready=0, a 5th walk_start is ignored, and check_x sequence cycles slots 0,1,2,3,0.
- hit_neighbor with waitrequest held for 3 cycles -> write and address stable for 4 cycles, walk_done pulses once on acceptance.
- DIR8=0, 200 moves -> every move changes exactly one coordinate by ±1; DIR8=1 -> every move changes at least one coordinate, none by more than 1.
